// File: rtl/piso_if.sv
// piso_if: valid/ready parallel load plus serial output bundle for piso_serializer
interface piso_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] Par_in;
  logic Load_valid;
  logic Load_ready;
  logic Data_out;
  logic Bit_valid;
  logic Busy;
  modport master (output Par_in, Load_valid, input Load_ready, Data_out, Bit_valid, Busy);
  modport slave (input Par_in, Load_valid, output Load_ready, Data_out, Bit_valid, Busy);
endinterface

// File: rtl/piso_serializer.sv
// piso_serializer: MSB-first PISO with one-word holding register; `define PARITY_EN appends an even-parity bit
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  piso_if.slave bus
);
`ifdef PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(FRAME + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  logic [0:0] state;
  logic [FRAME-1:0] sreg, hold, in_frame;
  logic hold_full, data_out, bit_valid, accept, reload;
  logic [CW-1:0] cnt;
`ifdef PARITY_EN
  assign in_frame = {bus.Par_in, ^bus.Par_in};
`else
  assign in_frame = bus.Par_in;
`endif
  assign accept = bus.Load_valid && !hold_full;
  assign reload = (state == IDLE) || (cnt == CW'(1));
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      sreg <= '0;
      hold <= '0;
      hold_full <= 1'b0;
      cnt <= '0;
      data_out <= 1'b0;
      bit_valid <= 1'b0;
    end else if (reload) begin
      // a held word has priority; ready is low then, so bypass can't collide
      if (hold_full || accept) begin
        sreg <= hold_full ? hold : in_frame;
        data_out <= hold_full ? hold[FRAME-1] : in_frame[FRAME-1];
        hold_full <= 1'b0;
        state <= SHIFT;
        cnt <= CW'(FRAME);
        bit_valid <= 1'b1;
      end else begin
        state <= IDLE;
        cnt <= '0;
        data_out <= 1'b0;
        bit_valid <= 1'b0;
      end
    end else begin
      sreg <= sreg << 1;
      data_out <= sreg[FRAME-2];
      cnt <= cnt - CW'(1);
      if (accept) begin
        hold <= in_frame;
        hold_full <= 1'b1;
      end
    end
  end
  assign bus.Load_ready = !hold_full;
  assign bus.Data_out = data_out;
  assign bus.Bit_valid = bit_valid;
  assign bus.Busy = (state == SHIFT) || hold_full;
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out stage that sits directly upstream of the 101/110 Mealy sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock, MSB first, on a single serial line that drives the detector's `Data_in`. A one-entry holding register lets the next word be accepted while the current one shifts, so consecutive words stream with no idle gap. An optional even-parity bit can be appended to each word.

## Interface
- WIDTH, 8, parallel word width in bits; legal range 2..32.

- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-low reset
- Par_in  input  WIDTH  parallel word; sampled on accept
- Load_valid  input  1  Par_in holds a valid word
- Load_ready  output  1  block can accept a word this cycle
- Data_out  output  1  serial bit stream; connects to the detector's Data_in
- Bit_valid  output  1  Data_out carries a real frame bit this cycle
- Busy  output  1  shift register or holding register is occupied

## Operation
- Internal state:
  - shift register `sreg[WIDTH-1:0]`;
  - holding register `hold[WIDTH-1:0]` with flag `hold_full`;
  - bit counter `cnt`, width clog2(FRAME+1), where FRAME = WIDTH, or WIDTH+1 with parity.
- FSM has two states:
  - IDLE: no frame in progress.
  - SHIFT: frame in progress; `cnt` = bits remaining including the current one.
- Accept: a handshake occurs on a rising edge with `Load_valid && Load_ready`. `Load_ready` = !hold_full (combinational from registered state).
- Frame reload point: on a rising edge where the FSM is IDLE, or SHIFT with cnt==1:
  - if hold_full, load `sreg` from `hold` and clear hold_full;
  - else if an accept occurs, load `sreg` directly from `Par_in` (bypass);
  - in both cases, go to SHIFT, cnt=FRAME, Data_out=sreg MSB, Bit_valid=1;
  - else go to IDLE, Data_out=0, Bit_valid=0.
- While in SHIFT with cnt>1:
  - shift `sreg` left once per clock, zero-fill;
  - Data_out = new MSB; decrement cnt;
  - an accept writes `hold` and sets hold_full.
- Simultaneous events:
  - Accept at the reload point with hold_full=1 cannot happen, because Load_ready=0.
  - Accept at the reload point with hold empty uses the bypass, and hold stays empty.
- Busy = (state==SHIFT) || hold_full.
- Idle line level is 0. The detector sees zeros between frames, which is the intended behaviour.
- Reset (rst==0 at a rising edge): state=IDLE, sreg=0, hold=0, hold_full=0, cnt=0, Data_out=0, Bit_valid=0. Reset mid-frame discards both the in-flight word and the held word. Load_ready reads 1 from the first cycle after reset.

## Timing
- Latency: a word accepted at edge k while idle has its MSB on Data_out in the cycle after edge k. The last data bit appears in the cycle after edge k+WIDTH-1.
- Throughput: one bit per clock. Back-to-back words produce no gap cycles as long as each following word is accepted before the current frame's last bit.
- Load_ready behaviour:
  - drops the cycle after a word is captured in `hold`;
  - rises the cycle after the reload point that empties `hold`.
- All outputs except Load_ready are registered.

## Configuration
- PARITY_EN:
  - Defined: FRAME=WIDTH+1. After the LSB, one extra bit equal to the even parity (XOR of all WIDTH bits) is emitted with Bit_valid=1. Parity is computed at load time and stored alongside the word.
  - Undefined: FRAME=WIDTH, and no parity logic is present.

## Test plan
- Basic shift: reset, then Par_in=8'hB6 accepted once. Data_out = 1,0,1,1,0,1,1,0 over 8 consecutive cycles with Bit_valid=1, then Data_out=0, Bit_valid=0, Busy=0.
- Back-to-back: words 8'hA5 accepted, then 8'h3C accepted during frame 1. Output is 16 contiguous bits, 1010010100111100, with no Bit_valid gap. Load_ready is low from the cycle after the 8'h3C capture until the reload.
- Bypass: new word presented exactly at the cnt==1 edge with hold empty. The next cycle shows the new MSB, and hold_full stays 0.
- Backpressure: Load_valid held high with hold full. No word is lost or duplicated. Scoreboard the serial stream against the input sequence 8'h01, 8'h80, 8'hFF.
- Reset mid-frame: drive rst=0 after 3 bits of 8'hB6, with a held word pending. Next cycle shows Data_out=0, Bit_valid=0, Load_ready=1, Busy=0. A fresh word then starts cleanly.
- PARITY_EN: 8'hB6 (five ones) emits 8 data bits followed by parity 1. 8'h3C emits parity 0. Frames are 9 bits, back-to-back without gaps.
